alu_sched: RTL and testbench

Two-requester scheduler that time-shares one combinational gate-level 4-bit ALU (operands A/B, controls CTRL0/CTRL1, results C/OVF). It arbitrates requests round-robin and drives registered, glitch-free operands into the ALU. It waits a programmable settle window so SDF-annotated path delays resolve, then captures C/OVF and returns a tagged response under valid/ready backpressure.

---
 rtl/alu_sched.sv | 164 ++++++++++++++++
 tb/tb_alu_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: two-requester round-robin scheduler in front of a shared
// combinational 4-bit ALU. Operands are launched from flops so the ALU inputs
// never glitch. The result is sampled after a programmable settle window and
// returned as a tagged response with valid/ready backpressure.
//
// Ports
//   clk, rst                 system clock, async active-high reset
//   r0_* / r1_*              requester channels (valid/ready, a, b, op)
//   resp_*                   response channel (valid/ready, id, c, ovf)
//   alu_a/alu_b/alu_ctrl*    registered drive into the external ALU
//   alu_c/alu_ovf            external ALU result
//   busy                     high whenever the FSM is not in IDLE
//
// State    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request; grant is combinational
// SETTLE   | operands launched; counting down until the ALU output is stable
// RESP     | captured result presented; waiting for resp_ready
module alu_sched #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [1:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [1:0]       r1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_c,
  output logic             resp_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ctrl0,
  output logic             alu_ctrl1,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_c_q, resp_c_d;
  logic             resp_ovf_q, resp_ovf_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_ctrl0_q, alu_ctrl0_d;
  logic             alu_ctrl1_q, alu_ctrl1_d;

  logic gnt0, gnt1;

  // Pointer only matters on contention; a lone requester always wins.
  assign gnt0 = r0_valid & (~r1_valid | ~ptr_q);
  assign gnt1 = r1_valid & (~r0_valid |  ptr_q);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_c_d     = resp_c_q;
    resp_ovf_d   = resp_ovf_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl0_d  = alu_ctrl0_q;
    alu_ctrl1_d  = alu_ctrl1_q;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        r0_ready = gnt0;
        r1_ready = gnt1;
        if (gnt0 | gnt1) begin
          alu_a_d     = gnt1 ? r1_a     : r0_a;
          alu_b_d     = gnt1 ? r1_b     : r0_b;
          alu_ctrl0_d = gnt1 ? r1_op[0] : r0_op[0];
          alu_ctrl1_d = gnt1 ? r1_op[1] : r0_op[1];
          id_d        = gnt1;
          cnt_d       = CNT_LOAD;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_c_d     = alu_c;
          resp_ovf_d   = alu_ovf;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = ~resp_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= 4'd0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_c_q     <= '0;
      resp_ovf_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl0_q  <= 1'b0;
      alu_ctrl1_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_c_q     <= resp_c_d;
      resp_ovf_q   <= resp_ovf_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl0_q  <= alu_ctrl0_d;
      alu_ctrl1_q  <= alu_ctrl1_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_c     = resp_c_q;
  assign resp_ovf   = resp_ovf_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl0  = alu_ctrl0_q;
  assign alu_ctrl1  = alu_ctrl1_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0] r0_a, r0_b, r1_a, r1_b;
  logic [1:0] r0_op, r1_op;
  logic       resp_valid, resp_ready, resp_id, resp_ovf;
  logic [3:0] resp_c, alu_a, alu_b, alu_c;
  logic       alu_ctrl0, alu_ctrl1, alu_ovf, busy;

  logic       s1_r0_valid, s1_r0_ready, s1_r1_ready;
  logic [3:0] s1_r0_a, s1_r0_b;
  logic       s1_resp_valid, s1_resp_ready, s1_resp_id, s1_resp_ovf;
  logic [3:0] s1_resp_c, s1_alu_a, s1_alu_b, s1_alu_c;
  logic       s1_alu_ctrl0, s1_alu_ctrl1, s1_alu_ovf, s1_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       id;
    logic [3:0] c;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // ALU stub: 4-bit adder with carry-out, 3 ns propagation.
  assign #3 {alu_ovf, alu_c}       = {1'b0, alu_a} + {1'b0, alu_b};
  assign #3 {s1_alu_ovf, s1_alu_c} = {1'b0, s1_alu_a} + {1'b0, s1_alu_b};

  alu_sched #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_ovf(resp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1),
    .alu_c(alu_c), .alu_ovf(alu_ovf), .busy(busy)
  );

  alu_sched #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(s1_r0_valid), .r0_ready(s1_r0_ready), .r0_a(s1_r0_a), .r0_b(s1_r0_b), .r0_op(2'b00),
    .r1_valid(1'b0), .r1_ready(s1_r1_ready), .r1_a(4'd0), .r1_b(4'd0), .r1_op(2'b00),
    .resp_valid(s1_resp_valid), .resp_ready(s1_resp_ready), .resp_id(s1_resp_id),
    .resp_c(s1_resp_c), .resp_ovf(s1_resp_ovf),
    .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_ctrl0(s1_alu_ctrl0), .alu_ctrl1(s1_alu_ctrl1),
    .alu_c(s1_alu_c), .alu_ovf(s1_alu_ovf), .busy(s1_busy)
  );

  function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    exp_t e;
    s     = {1'b0, a} + {1'b0, b};
    e.id  = id;
    e.c   = s[3:0];
    e.ovf = s[4];
    return e;
  endfunction

  // Scoreboard push on every request handshake edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (r0_valid && r0_ready) sb.push_back(model(1'b0, r0_a, r0_b));
      if (r1_valid && r1_ready) sb.push_back(model(1'b1, r1_a, r1_b));
    end
  end

  function automatic exp_t next_exp(output bit have);
    exp_t e;
    e    = '0;
    have = (sb.size() != 0);
    if (have) e = sb.pop_front();
    return e;
  endfunction

  task automatic idle_inputs();
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_op = 0;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_op = 0;
  endtask

  // Steps negedges until resp_valid is seen or the budget expires.
  task automatic wait_resp(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (resp_valid) ok = 1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1;
    idle_inputs();
    resp_ready = 0;
    s1_r0_valid = 0; s1_r0_a = 0; s1_r0_b = 0; s1_resp_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_ctrl0, alu_ctrl1} !== 10'd0) begin
      errors++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_ctrl0, alu_ctrl1});
    end
    checks++;
    if ({resp_valid, resp_id, resp_c, resp_ovf} !== 7'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_resp got=%h busy=%b exp=0", {resp_valid, resp_id, resp_c, resp_ovf}, busy);
    end
    rst = 0;
    r1_valid = 1;
    #1;
    checks++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
      errors++; $display("FAIL reset_lone_grant got=%b%b exp=10", r1_ready, r0_ready);
    end
    r1_valid = 0;
  endtask

  task automatic test_single();
    int n; bit ok, have; exp_t e;
    @(negedge clk);
    r0_a = 2; r0_b = 3; r0_op = 0; r0_valid = 1; resp_ready = 1;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant got=%b%b exp=10", r0_ready, r1_ready);
    end
    @(negedge clk);
    r0_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || r0_ready !== 1'b0 || alu_a !== 4'd2 || alu_b !== 4'd3 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL single_launch got busy=%b rdy=%b a=%0d b=%0d rv=%b exp 1 0 2 3 0",
                         busy, r0_ready, alu_a, alu_b, resp_valid);
    end
    wait_resp(10, n, ok);
    checks++;
    if (!ok || n != 2) begin
      errors++; $display("FAIL single_latency got=%0d ok=%b exp=2", n, ok);
    end
    e = next_exp(have);
    checks++;
    if (!have || {resp_id, resp_c, resp_ovf} !== e) begin
      errors++; $display("FAIL single_resp got=%h exp=%h have=%b", {resp_id, resp_c, resp_ovf}, e, have);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 4'd2 || alu_b !== 4'd3) begin
      errors++; $display("FAIL single_hold got rv=%b busy=%b a=%0d b=%0d exp 0 0 2 3", resp_valid, busy, alu_a, alu_b);
    end
  endtask

  task automatic test_overflow();
    int n; bit ok, have; exp_t e;
    r1_a = 9; r1_b = 8; r1_op = 3; r1_valid = 1; resp_ready = 1;
    @(negedge clk);
    r1_valid = 0;
    checks++;
    if (alu_ctrl0 !== 1'b1 || alu_ctrl1 !== 1'b1 || alu_a !== 4'd9) begin
      errors++; $display("FAIL ovf_ctrl got c0=%b c1=%b a=%0d exp 1 1 9", alu_ctrl0, alu_ctrl1, alu_a);
    end
    wait_resp(10, n, ok);
    e = next_exp(have);
    checks++;
    if (!ok || !have || {resp_id, resp_c, resp_ovf} !== e || e !== {1'b1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL ovf_resp got=%h exp=%h ok=%b", {resp_id, resp_c, resp_ovf}, e, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n; bit ok, have; exp_t e;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    sb.delete();
    rst = 0;
    r0_a = 7; r0_b = 7; r0_op = 0; r0_valid = 1;
    r1_a = 3; r1_b = 2; r1_op = 0; r1_valid = 1;
    resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wait_resp(20, n, ok);
      e = next_exp(have);
      checks++;
      if (!ok || resp_id !== 1'(i % 2)) begin
        errors++; $display("FAIL contention_order[%0d] got id=%b ok=%b exp=%0d", i, resp_id, ok, i % 2);
      end
      checks++;
      if (!have || {resp_id, resp_c, resp_ovf} !== e) begin
        errors++; $display("FAIL contention_resp[%0d] got=%h exp=%h", i, {resp_id, resp_c, resp_ovf}, e);
      end
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL contention_extra_accepts got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int n; bit ok, have; exp_t e;
    r0_a = 4; r0_b = 5; r0_op = 1; r0_valid = 1;
    r1_a = 1; r1_b = 1; r1_op = 2; r1_valid = 1;
    resp_ready = 0;
    wait_resp(20, n, ok);
    checks++;
    if (!ok || sb.size() != 1) begin
      errors++; $display("FAIL bp_first got ok=%b queued=%0d exp 1 1", ok, sb.size());
    end
    e = (sb.size() != 0) ? sb[0] : exp_t'('0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || {resp_id, resp_c, resp_ovf} !== e || busy !== 1'b1 ||
          r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got rv=%b resp=%h busy=%b rdy=%b%b exp 1 %h 1 00",
                           k, resp_valid, {resp_id, resp_c, resp_ovf}, busy, r0_ready, r1_ready, e);
      end
      @(negedge clk);
    end
    resp_ready = 1;
    e = next_exp(have);
    checks++;
    if (!have || {resp_id, resp_c, resp_ovf} !== e || e !== {1'b0, 4'd9, 1'b0}) begin
      errors++; $display("FAIL bp_resp got=%h exp=%h", {resp_id, resp_c, resp_ovf}, e);
    end
    @(negedge clk);
    checks++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept got rdy=%b%b rv=%b exp 10 0", r1_ready, r0_ready, resp_valid);
    end
    @(negedge clk);
    idle_inputs();
    wait_resp(10, n, ok);
    e = next_exp(have);
    checks++;
    if (!ok || !have || {resp_id, resp_c, resp_ovf} !== e || e.id !== 1'b1) begin
      errors++; $display("FAIL bp_drain got=%h exp=%h ok=%b", {resp_id, resp_c, resp_ovf}, e, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n; bit ok, have; exp_t e;
    // Complete an r0 op so the pointer moves to 1 before the reset.
    r0_a = 0; r0_b = 1; r0_valid = 1; resp_ready = 1;
    @(negedge clk);
    r0_valid = 0;
    wait_resp(10, n, ok);
    e = next_exp(have);
    checks++;
    if (!ok || !have || {resp_id, resp_c, resp_ovf} !== e) begin
      errors++; $display("FAIL mid_pre got=%h exp=%h ok=%b", {resp_id, resp_c, resp_ovf}, e, ok);
    end
    @(negedge clk);
    r1_a = 1; r1_b = 1; r1_op = 1; r1_valid = 1;
    @(negedge clk);
    r1_valid = 0;
    #1 rst = 1;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_ctrl0, alu_ctrl1} !== 10'd0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got alu=%h rv=%b busy=%b exp 0 0 0",
                         {alu_a, alu_b, alu_ctrl0, alu_ctrl1}, resp_valid, busy);
    end
    sb.delete();
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_ghost_resp[%0d] got rv=%b exp=0", k, resp_valid);
      end
    end
    r0_a = 6;  r0_b = 5;  r0_op = 0; r0_valid = 1;
    r1_a = 15; r1_b = 15; r1_op = 0; r1_valid = 1;
    wait_resp(20, n, ok);
    idle_inputs();
    e = next_exp(have);
    checks++;
    if (!ok || !have || {resp_id, resp_c, resp_ovf} !== e || e !== {1'b0, 4'd11, 1'b0}) begin
      errors++; $display("FAIL mid_after got=%h exp=%h ok=%b", {resp_id, resp_c, resp_ovf}, e, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_settle1();
    int n;
    logic [4:0] s;
    @(negedge clk);
    s1_r0_a = 2; s1_r0_b = 3; s1_r0_valid = 1; s1_resp_ready = 1;
    s = {1'b0, s1_r0_a} + {1'b0, s1_r0_b};
    #1;
    checks++;
    if (s1_r0_ready !== 1'b1) begin
      errors++; $display("FAIL s1_grant got=%b exp=1", s1_r0_ready);
    end
    @(negedge clk);
    s1_r0_valid = 0;
    n = 0;
    while (!s1_resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s1_resp_valid || n != 1) begin
      errors++; $display("FAIL s1_latency got=%0d rv=%b exp=1", n, s1_resp_valid);
    end
    checks++;
    if ({s1_resp_id, s1_resp_c, s1_resp_ovf} !== {1'b0, s[3:0], s[4]}) begin
      errors++; $display("FAIL s1_resp got=%h exp=%h", {s1_resp_id, s1_resp_c, s1_resp_ovf}, {1'b0, s[3:0], s[4]});
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    resp_ready = 0;
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_settle1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
